// File: rtl/spi_burst_ram_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_burst_ram_slave: SPI slave with private single-port RAM and bursts.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module spi_burst_ram_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit BURST_EN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic busy,
    output logic frame_abort
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam int C_MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int C_CNT_W = $clog2(C_MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RLOAD = 3'd4,
        S_RDATA = 3'd5
    } state_t;

    state_t                  r_state, w_state;
    logic [C_CNT_W-1:0]      r_cnt, w_cnt;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr;
    logic [DATA_WIDTH-1:0]   r_shift, w_shift;
    logic                    r_rd, w_rd;
    logic                    r_inc, w_inc;
    logic                    r_abort, w_abort;

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic                    w_mem_we;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [ADDR_WIDTH-1:0]   w_addr_step;
    logic                    w_last_addr;
    logic                    w_last_data;

    assign w_rd_word   = r_mem[r_addr];
    assign w_addr_step = (BURST_EN && r_inc) ? r_addr + ADDR_WIDTH'(1) : r_addr;
    assign w_last_addr = (r_cnt == C_CNT_W'(ADDR_WIDTH - 1));
    assign w_last_data = (r_cnt == C_CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_shift <= '0;
            r_rd    <= 1'b0;
            r_inc   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_addr  <= w_addr;
            r_shift <= w_shift;
            r_rd    <= w_rd;
            r_inc   <= w_inc;
            r_abort <= w_abort;
        end
    end

    // Memory is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && w_mem_we) begin
            r_mem[r_addr] <= w_mem_wdata;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_addr      = r_addr;
        w_shift     = r_shift;
        w_rd        = r_rd;
        w_inc       = r_inc;
        w_abort     = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = {r_shift[DATA_WIDTH-2:0], MOSI};

        // Deselect wins over any bit capture; only word-aligned data ends are clean.
        if (r_state != S_IDLE && SS_n) begin
            w_state = S_IDLE;
            w_cnt   = '0;
            case (r_state)
                S_WDATA, S_RDATA: w_abort = (r_cnt != '0);
                default:          w_abort = 1'b1;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!SS_n) begin
                        w_state = S_CMD;
                        w_cnt   = '0;
                    end
                end
                S_CMD: begin
                    if (r_cnt == '0) begin
                        w_rd  = MOSI;
                        w_cnt = r_cnt + C_CNT_W'(1);
                    end else begin
                        w_inc   = MOSI;
                        w_cnt   = '0;
                        w_state = S_ADDR;
                    end
                end
                S_ADDR: begin
                    w_addr = {r_addr[ADDR_WIDTH-2:0], MOSI};
                    if (w_last_addr) begin
                        w_cnt   = '0;
                        w_state = r_rd ? S_RLOAD : S_WDATA;
                    end else begin
                        w_cnt = r_cnt + C_CNT_W'(1);
                    end
                end
                S_WDATA: begin
                    w_shift = {r_shift[DATA_WIDTH-2:0], MOSI};
                    if (w_last_data) begin
                        w_mem_we = 1'b1;
                        w_addr   = w_addr_step;
                        w_cnt    = '0;
                    end else begin
                        w_cnt = r_cnt + C_CNT_W'(1);
                    end
                end
                S_RLOAD: begin
                    w_shift = w_rd_word;
                    w_addr  = w_addr_step;
                    w_cnt   = '0;
                    w_state = S_RDATA;
                end
                S_RDATA: begin
                    // Reload on the last bit so successive words stream gap-free.
                    if (w_last_data) begin
                        w_shift = w_rd_word;
                        w_addr  = w_addr_step;
                        w_cnt   = '0;
                    end else begin
                        w_shift = {r_shift[DATA_WIDTH-2:0], 1'b0};
                        w_cnt   = r_cnt + C_CNT_W'(1);
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            endcase
        end
    end

    assign MISO        = (r_state == S_RDATA) ? r_shift[DATA_WIDTH-1] : 1'b0;
    assign busy        = (r_state != S_IDLE);
    assign frame_abort = r_abort;

endmodule
`default_nettype wire
